// File: rtl/uart_event_streamer.sv
// uart_event_streamer: tagged FIFO of I2C sniffer events.
// Serialises each event to uart_tx as raw bytes or an ASCII hex record.
module uart_event_streamer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ASCII_MODE = 0,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          address_ready,
  input  logic [DATA_W-1:0]             address,
  input  logic                          reg_address_ready,
  input  logic [DATA_W-1:0]             reg_address,
  input  logic                          reg_data_ready,
  input  logic [DATA_W-1:0]             reg_data,
  output logic                          uart_tx_en,
  output logic [7:0]                    uart_tx_data,
  input  logic                          uart_tx_done,
  input  logic                          tx_busy,
  output logic                          sniff_success,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int EW    = DATA_W + 2;
  localparam int NHEX  = (DATA_W + 3) / 4;
  localparam int NBYTE = (DATA_W + 7) / 8;
  localparam int NCHAR = (ASCII_MODE != 0) ? NHEX + 2 : NBYTE;
  localparam int IW    = $clog2(NCHAR) + 1;

  localparam logic [IW-1:0]    LAST = IW'(NCHAR - 1);
  localparam logic [LW-1:0]    FULL = LW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT
  } state_t;

  state_t state, nstate;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] push_ent;
  logic [EW-1:0] cur;
  logic [IW-1:0] idx;

  logic          push_req, push, pop, full_drop;
  logic [1:0]    lost, drops;
  logic [CNT_W+1:0] cnt_sum;

  logic          load, adv, en_d, sniff_d;

  logic [DATA_W-1:0]  pay;
  logic [1:0]         tag;
  logic [8*NBYTE-1:0] raw_pad;
  logic [4*NHEX-1:0]  hex_pad;
  logic [7:0]         rbyte;
  logic [3:0]         nib;
  logic [7:0]         char_c;

  // Ingress arbitration: highest-priority pulse wins, the rest are lost
  always_comb begin
    push_req = 1'b0;
    push_ent = '0;
    lost     = 2'd0;
    priority case (1'b1)
      address_ready: begin
        push_req = 1'b1;
        push_ent = {2'd0, address};
        lost     = {1'b0, reg_address_ready} + {1'b0, reg_data_ready};
      end
      reg_address_ready: begin
        push_req = 1'b1;
        push_ent = {2'd1, reg_address};
        lost     = {1'b0, reg_data_ready};
      end
      reg_data_ready: begin
        push_req = 1'b1;
        push_ent = {2'd2, reg_data};
      end
      default: ;
    endcase
  end

  assign full_drop = push_req && (fifo_level == FULL) && !pop;
  assign push      = push_req && !full_drop;
  assign drops     = lost + {1'b0, full_drop};
  assign cnt_sum   = {2'b00, drop_count} + {{CNT_W{1'b0}}, drops};

  // Event storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers and registered occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // Drop accounting: sticky flag plus saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drops != 2'd0) begin
      overflow   <= 1'b1;
      drop_count <= (cnt_sum > {2'b00, CMAX}) ? CMAX : cnt_sum[CNT_W-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // FSM next state
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (fifo_level != '0) nstate = S_LOAD;
      S_LOAD:  nstate = S_START;
      S_START: if (!tx_busy) nstate = S_WAIT;
      S_WAIT:  if (uart_tx_done) nstate = (idx == LAST) ? S_IDLE : S_LOAD;
      default: nstate = S_IDLE;
    endcase
  end

  // FSM outputs (registered below)
  always_comb begin
    pop     = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    en_d    = 1'b0;
    sniff_d = 1'b0;
    unique case (state)
      S_IDLE:  pop  = (fifo_level != '0);
      S_LOAD:  load = 1'b1;
      S_START: en_d = !tx_busy;
      S_WAIT: begin
        adv     = uart_tx_done && (idx != LAST);
        sniff_d = uart_tx_done && (idx == LAST) && (tag == 2'd2);
      end
      default: ;
    endcase
  end

  // Character generator for the current record position
  always_comb begin
    raw_pad = '0;
    hex_pad = '0;
    raw_pad[DATA_W-1:0] = pay;
    hex_pad[DATA_W-1:0] = pay;
    rbyte = 8'h00;
    nib   = 4'h0;
    for (int i = 0; i < NBYTE; i++)
      if (int'(idx) == NBYTE - 1 - i) rbyte = raw_pad[8*i +: 8];
    for (int i = 0; i < NHEX; i++)
      if (int'(idx) == NHEX - i) nib = hex_pad[4*i +: 4];
    char_c = 8'h00;
    if (ASCII_MODE == 0)
      char_c = rbyte;
    else if (idx == '0)
      char_c = (tag == 2'd0) ? 8'h41 : (tag == 2'd1) ? 8'h52 : 8'h44;
    else if (idx == LAST)
      char_c = (tag == 2'd2) ? 8'h0A : 8'h20;
    else if (nib < 4'd10)
      char_c = 8'h30 + {4'h0, nib};
    else
      char_c = 8'h37 + {4'h0, nib};
  end

  assign pay = cur[DATA_W-1:0];
  assign tag = cur[EW-1:DATA_W];

  // Record datapath and registered UART strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= '0;
      idx           <= '0;
      uart_tx_data  <= 8'h00;
      uart_tx_en    <= 1'b0;
      sniff_success <= 1'b0;
    end else begin
      if (pop) begin
        cur <= mem[rd_ptr];
        idx <= '0;
      end else if (adv) begin
        idx <= idx + 1'b1;
      end
      if (load) uart_tx_data <= char_c;
      uart_tx_en    <= en_d;
      sniff_success <= sniff_d;
    end
  end

endmodule
